// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving a req/ack data-memory port
//
// Optional feature macro: MEM_TIMEOUT_EN (adds BUSY watchdog and bus_err_o port)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_res_mem              byte address or ALU result from EX/MEM
//   bypass_op2_mem           store data
//   mem_read_mem/_write_mem  load / store request (both set = load)
//   mask_mem                 size: 00 byte, 01 half, 10 word, 11 illegal
//   unsigned_load_mem        1 = zero-extend loads
//   reg_write_mem            write-back enable from EX/MEM
//   mem_to_reg_mem           write-back selects load data
//   dmem_*                   registered req/ack data-memory port
//   stall_req                holds the pipeline while an access is in flight
//   wb_data, reg_write_o     MEM/WB write-back value and qualified enable
//   misalign_o               misaligned / illegal access pulse
//   bus_err_o                watchdog expiry pulse (MEM_TIMEOUT_EN only)
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_res_mem,
    input  logic [DATA_W-1:0] bypass_op2_mem,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic [1:0]        mask_mem,
    input  logic              unsigned_load_mem,
    input  logic              reg_write_mem,
    input  logic              mem_to_reg_mem,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall_req,
    output logic [DATA_W-1:0] wb_data,
    output logic              reg_write_o,
    output logic              misalign_o
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              bus_err_o
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    logic              acc;
    logic              is_store;
    logic [1:0]        addr_lo;
    logic              misaligned;
    logic [3:0]        be_calc;
    logic [DATA_W-1:0] wdata_calc;
    logic              start;
    logic              timeout_hit;
    logic              bus_err;

    // Access attributes captured at request time so load alignment does not
    // depend on the frozen EX/MEM register staying perfectly stable.
    logic [1:0]        acc_lo;
    logic [1:0]        acc_mask;
    logic              acc_uns;
    logic [DATA_W-1:0] load_q;
    logic [DATA_W-1:0] load_ext;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        acc      = mem_read_mem | mem_write_mem;
        is_store = mem_write_mem & ~mem_read_mem;
        addr_lo  = alu_res_mem[1:0];

        case (mask_mem)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase

        case (mask_mem)
            2'b00: begin
                be_calc    = 4'b0001 << addr_lo;
                wdata_calc = {4{bypass_op2_mem[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_calc = {2{bypass_op2_mem[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = bypass_op2_mem;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = dmem_rdata[{acc_lo, 3'b000} +: 8];
        ld_half = dmem_rdata[{acc_lo[1], 4'b0000} +: 16];
        case (acc_mask)
            2'b00:   load_ext = acc_uns ? {{(DATA_W-8){1'b0}}, ld_byte}
                                        : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = acc_uns ? {{(DATA_W-16){1'b0}}, ld_half}
                                        : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    // The TIMEOUT_CYCLES-th ack-less BUSY cycle ends the access.
    assign timeout_hit = (state == BUSY) && !dmem_ack &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (start)
                to_cnt <= '0;
            else if (state == BUSY && !dmem_ack)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus_err_o = bus_err;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        stall_req   = 1'b0;
        misalign_o  = 1'b0;
        wb_data     = alu_res_mem;
        reg_write_o = 1'b0;

        case (state)
            IDLE: begin
                if (acc && !misaligned) begin
                    stall_req = 1'b1;
                    start     = 1'b1;
                    state_nxt = BUSY;
                end else if (acc) begin
                    misalign_o = 1'b1;
                end else begin
                    reg_write_o = reg_write_mem;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                if (dmem_ack || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                wb_data     = mem_to_reg_mem ? load_q : alu_res_mem;
                reg_write_o = reg_write_mem & ~bus_err;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Nothing may request a stall or flag a fault while held in reset.
        if (rst) begin
            stall_req  = 1'b0;
            misalign_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM state and bus registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= 4'b0000;
            load_q     <= '0;
            acc_lo     <= 2'b00;
            acc_mask   <= 2'b00;
            acc_uns    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {alu_res_mem[DATA_W-1:2], 2'b00};
                dmem_wdata <= wdata_calc;
                dmem_be    <= be_calc;
                acc_lo     <= addr_lo;
                acc_mask   <= mask_mem;
                acc_uns    <= unsigned_load_mem;
            end
            if (state == BUSY && dmem_ack) begin
                dmem_req <= 1'b0;
                load_q   <= load_ext;
            end else if (timeout_hit) begin
                dmem_req <= 1'b0;
                load_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res_mem;
    logic [31:0] bypass_op2_mem;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [1:0]  mask_mem;
    logic        unsigned_load_mem;
    logic        reg_write_mem;
    logic        mem_to_reg_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_req;
    logic [31:0] wb_data;
    logic        reg_write_o;
    logic        misalign_o;
`ifdef MEM_TIMEOUT_EN
    logic        bus_err_o;
`endif

    mem_access_unit dut (
        .clk               (clk),
        .rst               (rst),
        .alu_res_mem       (alu_res_mem),
        .bypass_op2_mem    (bypass_op2_mem),
        .mem_read_mem      (mem_read_mem),
        .mem_write_mem     (mem_write_mem),
        .mask_mem          (mask_mem),
        .unsigned_load_mem (unsigned_load_mem),
        .reg_write_mem     (reg_write_mem),
        .mem_to_reg_mem    (mem_to_reg_mem),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_be           (dmem_be),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .stall_req         (stall_req),
        .wb_data           (wb_data),
        .reg_write_o       (reg_write_o),
        .misalign_o        (misalign_o)
`ifdef MEM_TIMEOUT_EN
        ,
        .bus_err_o         (bus_err_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        rw;
        int          req_c;
        int          stall_c;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %0s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops bus expectations on each new request and write-back
    // expectations in the cycle after the acknowledged BUSY cycle.
    // ------------------------------------------------------------------
    int   req_cnt   = 0;
    int   stall_cnt = 0;
    logic prev_req  = 1'b0;
    logic done_next = 1'b0;

    always @(negedge clk) begin
        bus_t eb;
        wb_t  ew;
        if (rst) begin
            req_cnt   = 0;
            stall_cnt = 0;
            prev_req  = 1'b0;
            done_next = 1'b0;
        end else begin
            if (stall_req) stall_cnt++;
            if (dmem_req)  req_cnt++;
            if (dmem_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    eb = bus_q.pop_front();
                    chk("dmem_addr",  dmem_addr,  eb.addr);
                    chk("dmem_we",    {31'd0, dmem_we}, {31'd0, eb.we});
                    chk("dmem_be",    {28'd0, dmem_be}, {28'd0, eb.be});
                    chk("dmem_wdata", dmem_wdata, eb.wdata);
                end
            end
            if (done_next) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    ew = wb_q.pop_front();
                    chk("wb_data",      wb_data, ew.data);
                    chk("reg_write_o",  {31'd0, reg_write_o}, {31'd0, ew.rw});
                    chk("req_cycles",   req_cnt, ew.req_c);
                    chk("stall_cycles", stall_cnt, ew.stall_c);
                    chk("done_stall",   {31'd0, stall_req}, 32'd0);
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
`ifdef MEM_TIMEOUT_EN
            if (bus_err_o) begin
                req_cnt   = 0;
                stall_cnt = 0;
            end
`endif
            done_next = dmem_req && dmem_ack;
            prev_req  = dmem_req;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic set_nop();
        mem_read_mem      = 1'b0;
        mem_write_mem     = 1'b0;
        mask_mem          = 2'b10;
        unsigned_load_mem = 1'b0;
        reg_write_mem     = 1'b0;
        mem_to_reg_mem    = 1'b0;
        alu_res_mem       = 32'h0;
        bypass_op2_mem    = 32'h0;
    endtask

    task automatic set_op(input logic rd, input logic wr, input logic [1:0] mk,
                          input logic uns, input logic [31:0] addr, input logic [31:0] op2,
                          input logic rw, input logic m2r);
        mem_read_mem      = rd;
        mem_write_mem     = wr;
        mask_mem          = mk;
        unsigned_load_mem = uns;
        alu_res_mem       = addr;
        bypass_op2_mem    = op2;
        reg_write_mem     = rw;
        mem_to_reg_mem    = m2r;
    endtask

    // Ack arrives in the k-th BUSY cycle; inputs held through DONE.
    task automatic mem_op(input logic rd, input logic wr, input logic [1:0] mk,
                          input logic uns, input logic [31:0] addr, input logic [31:0] op2,
                          input logic rw, input logic m2r, input int k,
                          input logic [31:0] rdata);
        set_op(rd, wr, mk, uns, addr, op2, rw, m2r);
        repeat (k) @(posedge clk);
        #1;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        @(posedge clk);
        #1;
        set_nop();
    endtask

    task automatic mis_op(input string name, input logic [1:0] mk, input logic [31:0] addr);
        set_op(1'b1, 1'b0, mk, 1'b0, addr, 32'h0, 1'b1, 1'b1);
        #1;
        chk({name, "_misalign"},  {31'd0, misalign_o},  32'd1);
        chk({name, "_stall"},     {31'd0, stall_req},   32'd0);
        chk({name, "_reg_write"}, {31'd0, reg_write_o}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_no_req"},    {31'd0, dmem_req},    32'd0);
        set_nop();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",      {31'd0, dmem_req},   32'd0);
        chk("rst_we",       {31'd0, dmem_we},    32'd0);
        chk("rst_be",       {28'd0, dmem_be},    32'd0);
        chk("rst_stall",    {31'd0, stall_req},  32'd0);
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // lw 0x100, ack in third BUSY cycle
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{32'hDEADBEEF, 1'b1, 3, 4});
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1, 3, 32'hDEADBEEF);

        // lb / lbu 0x103
        bus_q.push_back('{32'h100, 1'b0, 4'b1000, 32'h0});
        wb_q.push_back('{32'hFFFFFF80, 1'b1, 1, 2});
        mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 1'b1, 1, 32'h80FF0000);
        bus_q.push_back('{32'h100, 1'b0, 4'b1000, 32'h0});
        wb_q.push_back('{32'h00000080, 1'b1, 1, 2});
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 1'b1, 1, 32'h80FF0000);

        // sh 0x202
        bus_q.push_back('{32'h200, 1'b1, 4'b1100, 32'hABCDABCD});
        wb_q.push_back('{32'h202, 1'b0, 2, 3});
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 1'b0, 1'b0, 2, 32'h0);

        // lh 0x102 signed, lhu 0x100
        bus_q.push_back('{32'h100, 1'b0, 4'b1100, 32'h0});
        wb_q.push_back('{32'hFFFF8001, 1'b1, 1, 2});
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b1, 1'b1, 1, 32'h80017FFF);
        bus_q.push_back('{32'h100, 1'b0, 4'b0011, 32'h0});
        wb_q.push_back('{32'h0000F00D, 1'b1, 1, 2});
        mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b1, 1'b1, 1, 32'h1234F00D);

        // sb 0x101, sw 0x104
        bus_q.push_back('{32'h100, 1'b1, 4'b0010, 32'hA5A5A5A5});
        wb_q.push_back('{32'h101, 1'b0, 1, 2});
        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 1'b0, 1'b0, 1, 32'h0);
        bus_q.push_back('{32'h104, 1'b1, 4'b1111, 32'hCAFEF00D});
        wb_q.push_back('{32'h104, 1'b0, 1, 2});
        mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 1, 32'h0);

        // read and write both set: treated as a load
        bus_q.push_back('{32'h108, 1'b0, 4'b1111, 32'h55AA55AA});
        wb_q.push_back('{32'h11223344, 1'b1, 2, 3});
        mem_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h108, 32'h55AA55AA, 1'b1, 1'b1, 2, 32'h11223344);

        // misaligned / illegal
        mis_op("lw101", 2'b10, 32'h101);
        mis_op("lh103", 2'b01, 32'h103);
        mis_op("mask11", 2'b11, 32'h100);

        // non-memory pass-through plus stray ack
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 1'b1, 1'b0);
        dmem_ack = 1'b1;
        #1;
        chk("pt_wb_data",   wb_data, 32'h55);
        chk("pt_reg_write", {31'd0, reg_write_o}, 32'd1);
        chk("pt_stall",     {31'd0, stall_req},   32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("stray_ack_req",   {31'd0, dmem_req},  32'd0);
        chk("stray_ack_stall", {31'd0, stall_req}, 32'd0);
        chk("stray_ack_wb",    wb_data, 32'h55);
        set_nop();

        // reset during BUSY, then a late ack
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        set_nop();
        #1;
        chk("rst_busy_req",   {31'd0, dmem_req},  32'd0);
        chk("rst_busy_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("late_ack_req",   {31'd0, dmem_req},  32'd0);
        chk("late_ack_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_idle_wb", {31'd0, reg_write_o}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        begin
            int   busy_seen;
            logic hit;
            busy_seen = 0;
            hit       = 1'b0;
            bus_q.push_back('{32'h10C, 1'b0, 4'b1111, 32'h0});
            set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 1'b1, 1'b1);
            for (int i = 0; i < 40 && !hit; i++) begin
                @(posedge clk);
                #1;
                if (bus_err_o) hit = 1'b1;
                else if (dmem_req) busy_seen++;
            end
            chk("to_bus_err",    {31'd0, hit}, 32'd1);
            chk("to_busy_cyc",   busy_seen, 32'd16);
            chk("to_req",        {31'd0, dmem_req},    32'd0);
            chk("to_reg_write",  {31'd0, reg_write_o}, 32'd0);
            chk("to_wb_data",    wb_data, 32'h0);
            @(posedge clk);
            #1;
            set_nop();
            chk("to_err_pulse",  {31'd0, bus_err_o}, 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_drained", bus_q.size(), 32'd0);
        chk("wb_q_drained",  wb_q.size(),  32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
